mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
Two-port arbiter that shares the single main_memory port (33-bit address, 128-bit line, en_read/en_write/ram_ack handshake) between two cache requesters, e.g. an instruction cache on port 0 and a data cache on port 1. It grants one requester at a time using round-robin priority. A lock input keeps a writeback followed by its line fill atomic. The block sits between the cache controllers and main_memory and drives the memory enables and address.

Parameters:
ADDR_W, 33, memory address width
DATA_W, 128, cache line width
TIMEOUT, 64, ram_ack watchdog limit in cycles (only with ARB_TIMEOUT_EN)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
req0_rd / req1_rd  in  1  read request, held until matching ack
req0_wr / req1_wr  in  1  write request, held until matching ack
req0_lock / req1_lock  in  1  keep grant for the next transaction
req0_addr / req1_addr  in  ADDR_W  line address
req0_wdata / req1_wdata  in  DATA_W  line to write
ack0 / ack1  out  1  one-cycle completion pulse
rdata  out  DATA_W  read line, valid while ack0 or ack1 is high
grant  out  2  one-hot current owner, 00 when idle
mem_addr  out  ADDR_W  to main_memory addr
mem_wdata  out  DATA_W  to main_memory data_in
mem_en_read  out  1  to main_memory en_read
mem_en_write  out  1  to main_memory en_write
mem_ack  in  1  ram_ack from main_memory (one-cycle pulse)
mem_rdata  in  DATA_W  data_out from main_memory
err  out  1  sticky timeout flag (ARB_TIMEOUT_EN only, else tied 0)

Behaviour:
- Reset (async, active-low) values:
  - FSM = IDLE; all outputs 0; rdata = 0.
  - Round-robin pointer prefers port 0; lock owner cleared.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - Sample requests; port N is pending when reqN_rd or reqN_wr is high.
  - Lock owner set: only that port is considered. The other port waits.
  - Otherwise, one port pending: grant it. Both pending: grant the port the pointer prefers.
  - On grant, register addr, wdata and op into grant, mem_addr, mem_wdata. Next state BUSY.
  - Enables rise on the cycle after the request is first sampled.
- BUSY:
  - mem_en_read or mem_en_write is held high with stable address and data until mem_ack.
  - If rd and wr are both high, write wins and rd is ignored for this transaction.
  - Requester signals are not re-sampled in BUSY.
- mem_ack in BUSY:
  - Next state RESP.
  - Enables drop to 0.
  - Latch mem_rdata into rdata (reads only; writes leave rdata unchanged).
- RESP (exactly 1 cycle):
  - ackN = 1 for the owner.
  - Requests are ignored, so the requester can drop its request before the next IDLE sample.
  - Pointer moves to prefer the other port.
  - If reqN_lock is high, lock owner = N; else lock is cleared.
  - Next state IDLE; grant = 00.
- Minimum transaction = 3 cycles (IDLE sample, BUSY with immediate mem_ack, RESP). Back-to-back grants are separated by one IDLE cycle.
- mem_ack outside BUSY is ignored.
- Reset asserted mid-transaction: immediate return to reset state. No ack is produced. The requester must reissue.
- grant is always one-hot or zero. ack0 and ack1 are never high together.

Optional Feature:
ARB_TIMEOUT_EN:
- Defined:
  - A counter of width clog2(TIMEOUT+1) counts BUSY cycles.
  - It clears on entry to BUSY.
  - On reaching TIMEOUT without mem_ack: enables drop, go to RESP, ack the owner with rdata = 0, and set err.
  - err is sticky until reset. Lock is cleared on timeout.
- Undefined: no counter; BUSY waits indefinitely; err is tied 0.

Test Plan:
- Port 0 read at 0x0_0000_0040, mem_ack 2 cycles after en_read, mem_rdata = 0x..DEADBEEF -> mem_en_read high 2 cycles, ack0 pulse 1 cycle later, rdata = 0x..DEADBEEF, ack1 stays 0.
- Both ports request reads in the same cycle after reset -> port 0 is served first, port 1 next; grant sequence 01, 00, 10.
- Port 1 write with lock=1, then port 1 read, while port 0 requests continuously -> port 1 write and read complete back-to-back; port 0 is granted only after port 1 lock=0 at its RESP.
- Port 0 sets rd and wr together with wdata = 0xA5 pattern -> only mem_en_write asserts and mem_wdata = 0xA5 pattern; rdata unchanged.
- Reset pulled low during BUSY -> all outputs 0 that cycle, no ack; request reissued after reset -> completes normally.
- ARB_TIMEOUT_EN defined, TIMEOUT=8, mem_ack never arrives -> enables drop after 8 BUSY cycles, ack0 with rdata = 0, err = 1 and stays high.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundle between two cache requesters, the mem_arbiter and the main_memory port.
// The arbiter takes the slave view; requesters and the memory model take the master view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 33,
  parameter int DATA_W = 128
);
  // Handshake: a requester raises reqN_rd/reqN_wr with stable addr/wdata/lock and holds them
  // until ackN pulses for one cycle (rdata valid in that cycle). The arbiter holds
  // mem_en_read/mem_en_write with stable mem_addr/mem_wdata until a one-cycle mem_ack.
  logic              req0_rd;
  logic              req0_wr;
  logic              req0_lock;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata;
  logic              req1_rd;
  logic              req1_wr;
  logic              req1_lock;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata;
  logic              ack0;
  logic              ack1;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        grant;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_en_read;
  logic              mem_en_write;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              err;

  modport master (
    output req0_rd, req0_wr, req0_lock, req0_addr, req0_wdata,
    output req1_rd, req1_wr, req1_lock, req1_addr, req1_wdata,
    input  ack0, ack1, rdata, grant,
    input  mem_addr, mem_wdata, mem_en_read, mem_en_write,
    output mem_ack, mem_rdata,
    input  err
  );

  modport slave (
    input  req0_rd, req0_wr, req0_lock, req0_addr, req0_wdata,
    input  req1_rd, req1_wr, req1_lock, req1_addr, req1_wdata,
    output ack0, ack1, rdata, grant,
    output mem_addr, mem_wdata, mem_en_read, mem_en_write,
    input  mem_ack, mem_rdata,
    output err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin two-port arbiter in front of main_memory, with lock for writeback+fill pairs.
// Optional ram_ack watchdog with sticky err is enabled by defining ARB_TIMEOUT_EN.
module mem_arbiter #(
  parameter int ADDR_W  = 33,
  parameter int DATA_W  = 128,
  parameter int TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus,
  output logic [1:0]   dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              wr_q, wr_d;
  logic              en_rd_q, en_rd_d;
  logic              en_wr_q, en_wr_d;
  logic [1:0]        ack_q, ack_d;
  logic              ptr_q, ptr_d;
  logic              lock_vld_q, lock_vld_d;
  logic              lock_port_q, lock_port_d;

  logic              pend0, pend1;
  logic              cand0, cand1;
  logic              owner_lock;
  logic              timed_out;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              to_q, to_d;
  logic              err_q, err_d;
`endif

  assign pend0 = bus.req0_rd | bus.req0_wr;
  assign pend1 = bus.req1_rd | bus.req1_wr;
  // A lock owner hides the other port from arbitration until the owner releases.
  assign cand0 = pend0 & (~lock_vld_q | ~lock_port_q);
  assign cand1 = pend1 & (~lock_vld_q |  lock_port_q);
  assign owner_lock = grant_q[1] ? bus.req1_lock : bus.req0_lock;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    wr_d        = wr_q;
    en_rd_d     = en_rd_q;
    en_wr_d     = en_wr_q;
    ack_d       = 2'b00;
    ptr_d       = ptr_q;
    lock_vld_d  = lock_vld_q;
    lock_port_d = lock_port_q;
    timed_out   = 1'b0;
`ifdef ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    to_d        = to_q;
    err_d       = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (cand0 && (!cand1 || !ptr_q)) begin
          state_d = BUSY;
          grant_d = 2'b01;
          addr_d  = bus.req0_addr;
          wdata_d = bus.req0_wdata;
          wr_d    = bus.req0_wr;
          en_wr_d = bus.req0_wr;
          en_rd_d = ~bus.req0_wr;
`ifdef ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else if (cand1) begin
          state_d = BUSY;
          grant_d = 2'b10;
          addr_d  = bus.req1_addr;
          wdata_d = bus.req1_wdata;
          wr_d    = bus.req1_wr;
          en_wr_d = bus.req1_wr;
          en_rd_d = ~bus.req1_wr;
`ifdef ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      BUSY: begin
`ifdef ARB_TIMEOUT_EN
        cnt_d = cnt_q + 1'b1;
        if (!bus.mem_ack && cnt_q == CNT_W'(TIMEOUT - 1)) begin
          timed_out = 1'b1;
        end
`endif
        if (bus.mem_ack || timed_out) begin
          state_d = RESP;
          en_rd_d = 1'b0;
          en_wr_d = 1'b0;
          ack_d   = grant_q;
          if (timed_out) begin
            rdata_d = '0;
          end else if (!wr_q) begin
            rdata_d = bus.mem_rdata;
          end
`ifdef ARB_TIMEOUT_EN
          to_d  = timed_out;
          err_d = err_q | timed_out;
`endif
        end
      end
      RESP: begin
        state_d     = IDLE;
        grant_d     = 2'b00;
        ptr_d       = grant_q[0];
        lock_port_d = grant_q[1];
        lock_vld_d  = owner_lock;
`ifdef ARB_TIMEOUT_EN
        // A timed-out owner must not keep the memory port for a follow-up.
        if (to_q) begin
          lock_vld_d = 1'b0;
        end
        to_d = 1'b0;
`endif
      end
      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
        en_rd_d = 1'b0;
        en_wr_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      grant_q     <= 2'b00;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      wr_q        <= 1'b0;
      en_rd_q     <= 1'b0;
      en_wr_q     <= 1'b0;
      ack_q       <= 2'b00;
      ptr_q       <= 1'b0;
      lock_vld_q  <= 1'b0;
      lock_port_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      wr_q        <= wr_d;
      en_rd_q     <= en_rd_d;
      en_wr_q     <= en_wr_d;
      ack_q       <= ack_d;
      ptr_q       <= ptr_d;
      lock_vld_q  <= lock_vld_d;
      lock_port_q <= lock_port_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      to_q  <= to_d;
      err_q <= err_d;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.grant        = grant_q;
  assign bus.mem_addr     = addr_q;
  assign bus.mem_wdata    = wdata_q;
  assign bus.mem_en_read  = en_rd_q;
  assign bus.mem_en_write = en_wr_q;
  assign bus.ack0         = ack_q[0];
  assign bus.ack1         = ack_q[1];
  assign bus.rdata        = rdata_q;
  assign dbg_state        = state_q;

endmodule
